// File: rtl/out_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : out_buf_pkg
//  Purpose  : Shared definitions for the output-peripheral store path:
//             peripheral base addresses inside the 64-byte output region,
//             load/store func3 encodings (shared with the input buffer),
//             the blank seven-segment pattern and a byte-map helper.
//  Revision : 1.0 - initial release
// ============================================================================
package out_buf_pkg;

    // Base byte addresses of each peripheral inside the output region
    localparam logic [7:0] LEDR_ADDR = 8'h00;
    localparam logic [7:0] LEDG_ADDR = 8'h10;
    localparam logic [7:0] HEX_ADDR  = 8'h20;
    localparam logic [7:0] LCD_ADDR  = 8'h30;
    localparam logic [7:0] END_ADDR  = 8'h3F;

    // Active-low segments: all ones turns every segment off
    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // func3 encodings. Loads and stores reuse the same code points, so they
    // live in two enums rather than one (an enum cannot repeat a value).
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } ld_func3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } st_func3_e;

    // True for byte addresses backed by a peripheral register
    function automatic logic is_mapped(input logic [7:0] addr);
        return (addr[7:2] == LEDR_ADDR[7:2]) ||
               (addr[7:2] == LEDG_ADDR[7:2]) ||
               (addr[7:3] == HEX_ADDR[7:3])  ||
               (addr[7:2] == LCD_ADDR[7:2]);
    endfunction

endpackage : out_buf_pkg
`default_nettype wire

// File: rtl/out_buf_byte_en.sv
`default_nettype none
// ============================================================================
//  Module   : out_buf_byte_en
//  Purpose  : Store decode for the output buffer. From func3, the byte
//             address and the write strobe it builds a per-byte write enable
//             and, for each enabled byte, the store-data lane that feeds it.
//  Ports    : i_wren       store strobe
//             i_control    func3 of the store
//             i_addr       byte address within the output region
//             o_byte_en    one enable per register byte
//             o_byte_lane  2-bit source lane per register byte
//  Revision : 1.0 - initial release
// ============================================================================
module out_buf_byte_en
    import out_buf_pkg::*;
#(
    parameter int O_BUF_SIZE = 64
) (
    input  logic                    i_wren,
    input  logic [2:0]              i_control,
    input  logic [7:0]              i_addr,
    output logic [O_BUF_SIZE-1:0]   o_byte_en,
    output logic [2*O_BUF_SIZE-1:0] o_byte_lane
);

    localparam int AW = $clog2(O_BUF_SIZE);

    logic [7:0] w_base;
    logic [2:0] w_nbytes;
    logic [8:0] w_tgt [4];

    always_comb begin
        o_byte_en   = '0;
        o_byte_lane = '0;
        w_base      = i_addr;
        w_nbytes    = 3'd0;
        for (int k = 0; k < 4; k++) begin
            w_tgt[k] = 9'h000;
        end

        case (i_control)
            SB: begin
                w_nbytes = 3'd1;
            end
            SH: begin
                w_base   = i_addr & 8'hFE;
                w_nbytes = 3'd2;
            end
            SW: begin
                w_base   = i_addr & 8'hFC;
                w_nbytes = 3'd4;
            end
            default: w_nbytes = 3'd0;
        endcase

        // Target address is kept one bit wider so a lane landing past 8'hFF
        // cannot wrap back into the mapped region.
        for (int k = 0; k < 4; k++) begin
            w_tgt[k] = {1'b0, w_base} + 9'(k);
            if (i_wren && (3'(k) < w_nbytes) &&
                (w_tgt[k] < 9'(O_BUF_SIZE)) && is_mapped(w_tgt[k][7:0])) begin
                o_byte_en[w_tgt[k][AW-1:0]]                = 1'b1;
                o_byte_lane[{w_tgt[k][AW-1:0], 1'b0} +: 2] = 2'(k);
            end
        end
    end

endmodule : out_buf_byte_en
`default_nettype wire

// File: rtl/output_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : output_buffer
//  Purpose  : Memory-mapped store path for the on-board output peripherals.
//             SB/SH/SW stores land in a 64-byte register file that directly
//             drives red/green LEDs, eight seven-segment digits and the LCD.
//  Ports    : i_clk, i_rst           clock, synchronous active-high reset
//             i_wren                 store strobe (output region selected)
//             i_control              func3 of the current load/store
//             i_out_buf_addr         byte address within the region
//             i_st_data              store data, lane 0 = bits [7:0]
//             o_ld_data              readback (OUT_BUF_READBACK_EN only)
//             o_io_ledr/ledg/lcd     32-bit peripheral words
//             o_io_hex0..7           seven-segment digits, active-low
//  Config   : OUT_BUF_READBACK_EN - builds o_ld_data and the read mux
//  Revision : 1.0 - initial release
// ============================================================================
module output_buffer
    import out_buf_pkg::*;
#(
    parameter int         O_BUF_SIZE = 64,
    parameter logic [7:0] HEX_RST    = 8'h7F
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wren,
    input  logic [2:0]  i_control,
    input  logic [7:0]  i_out_buf_addr,
    input  logic [31:0] i_st_data,
`ifdef OUT_BUF_READBACK_EN
    output logic [31:0] o_ld_data,
`endif
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);

    logic [O_BUF_SIZE-1:0]   w_byte_en;
    logic [2*O_BUF_SIZE-1:0] w_byte_lane;
    logic [8*O_BUF_SIZE-1:0] w_bytes;
    logic [7:0]              w_st_lane [4];

    assign w_st_lane[0] = i_st_data[7:0];
    assign w_st_lane[1] = i_st_data[15:8];
    assign w_st_lane[2] = i_st_data[23:16];
    assign w_st_lane[3] = i_st_data[31:24];

    out_buf_byte_en #(
        .O_BUF_SIZE (O_BUF_SIZE)
    ) u_byte_en (
        .i_wren      (i_wren),
        .i_control   (i_control),
        .i_addr      (i_out_buf_addr),
        .o_byte_en   (w_byte_en),
        .o_byte_lane (w_byte_lane)
    );

    // Only peripheral-backed bytes get a flop; holes in the map read as 0.
    for (genvar i = 0; i < O_BUF_SIZE; i++) begin : g_byte
        localparam logic [7:0] c_addr = 8'(i);
        if (is_mapped(c_addr)) begin : g_mapped
            localparam logic [7:0] c_rst =
                (c_addr[7:3] == HEX_ADDR[7:3]) ? HEX_RST : 8'h00;
            logic [7:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_q <= c_rst;
                end else if (w_byte_en[i]) begin
                    r_q <= w_st_lane[w_byte_lane[2*i +: 2]];
                end
            end
            assign w_bytes[8*i +: 8] = r_q;
        end else begin : g_unmapped
            assign w_bytes[8*i +: 8] = 8'h00;
        end
    end

    assign o_io_ledr = w_bytes[8*int'(LEDR_ADDR) +: 32];
    assign o_io_ledg = w_bytes[8*int'(LEDG_ADDR) +: 32];
    assign o_io_lcd  = w_bytes[8*int'(LCD_ADDR)  +: 32];
    assign o_io_hex0 = w_bytes[8*(int'(HEX_ADDR) + 0) +: 7];
    assign o_io_hex1 = w_bytes[8*(int'(HEX_ADDR) + 1) +: 7];
    assign o_io_hex2 = w_bytes[8*(int'(HEX_ADDR) + 2) +: 7];
    assign o_io_hex3 = w_bytes[8*(int'(HEX_ADDR) + 3) +: 7];
    assign o_io_hex4 = w_bytes[8*(int'(HEX_ADDR) + 4) +: 7];
    assign o_io_hex5 = w_bytes[8*(int'(HEX_ADDR) + 5) +: 7];
    assign o_io_hex6 = w_bytes[8*(int'(HEX_ADDR) + 6) +: 7];
    assign o_io_hex7 = w_bytes[8*(int'(HEX_ADDR) + 7) +: 7];

`ifdef OUT_BUF_READBACK_EN
    // Reads see the registers before this cycle's store commits, so a
    // same-cycle load/store to one byte returns the old contents.
    logic [7:0] w_rd_base;
    logic [8:0] w_rd_addr [4];
    logic [7:0] w_rd_b    [4];

    always_comb begin
        w_rd_base = i_out_buf_addr;
        case (i_control)
            LH, LHU: w_rd_base = i_out_buf_addr & 8'hFE;
            LW:      w_rd_base = i_out_buf_addr & 8'hFC;
            default: w_rd_base = i_out_buf_addr;
        endcase

        for (int k = 0; k < 4; k++) begin
            w_rd_addr[k] = {1'b0, w_rd_base} + 9'(k);
            if (w_rd_addr[k] <= {1'b0, END_ADDR}) begin
                w_rd_b[k] = w_bytes[{w_rd_addr[k][5:0], 3'b000} +: 8];
            end else begin
                w_rd_b[k] = 8'h00;
            end
        end

        case (i_control)
            LB:      o_ld_data = {{24{w_rd_b[0][7]}}, w_rd_b[0]};
            LBU:     o_ld_data = {24'h000000, w_rd_b[0]};
            LH:      o_ld_data = {{16{w_rd_b[1][7]}}, w_rd_b[1], w_rd_b[0]};
            LHU:     o_ld_data = {16'h0000, w_rd_b[1], w_rd_b[0]};
            LW:      o_ld_data = {w_rd_b[3], w_rd_b[2], w_rd_b[1], w_rd_b[0]};
            default: o_ld_data = 32'h0000_0000;
        endcase
    end
`endif

    // Decode bits for unmapped bytes and hex bit 7 have no consumer in
    // every build; fold them here so they are visibly intentional.
    logic w_unused;
    assign w_unused = ^{w_byte_en, w_byte_lane, w_bytes};

endmodule : output_buffer
`default_nettype wire

// File: tb/tb_output_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_buffer
//  Purpose  : Directed self-checking bench for output_buffer. Readback
//             checks are compiled only with OUT_BUF_READBACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_buffer;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [2:0]  control;
    logic [7:0]  addr;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hex [8];

    int n_vec  = 0;
    int n_miss = 0;

    output_buffer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wren         (wren),
        .i_control      (control),
        .i_out_buf_addr (addr),
        .i_st_data      (st_data),
`ifdef OUT_BUF_READBACK_EN
        .o_ld_data      (ld_data),
`endif
        .o_io_ledr      (ledr),
        .o_io_ledg      (ledg),
        .o_io_hex0      (hex[0]),
        .o_io_hex1      (hex[1]),
        .o_io_hex2      (hex[2]),
        .o_io_hex3      (hex[3]),
        .o_io_hex4      (hex[4]),
        .o_io_hex5      (hex[5]),
        .o_io_hex6      (hex[6]),
        .o_io_hex7      (hex[7]),
        .o_io_lcd       (lcd)
    );

`ifndef OUT_BUF_READBACK_EN
    assign ld_data = 32'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] d);
        wren    = 1'b1;
        control = f3;
        addr    = a;
        st_data = d;
        tick();
        wren    = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [7:0] a, input logic [31:0] exp);
`ifdef OUT_BUF_READBACK_EN
        wren    = 1'b0;
        control = f3;
        addr    = a;
        #1;
        check_val(tag, ld_data, exp);
`endif
    endtask

    task automatic check_hex_blank_except(input int skip_a, input int skip_b);
        for (int i = 0; i < 8; i++) begin
            if (i != skip_a && i != skip_b)
                check_val($sformatf("hex%0d_blank", i), {25'h0, hex[i]}, 32'h7F);
        end
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; control = 3'b000; addr = 8'h00; st_data = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_val("rst_ledr", ledr, 32'h0);
        check_val("rst_ledg", ledg, 32'h0);
        check_val("rst_lcd",  lcd,  32'h0);
        check_hex_blank_except(-1, -1);
        load_chk("rd_lw_hex", 3'b010, 8'h20, 32'h7F7F7F7F);

        // Word store aligns down to 8'h00
        store(3'b010, 8'h01, 32'hDEADBEEF);
        check_val("sw_ledr", ledr, 32'hDEADBEEF);
        load_chk("rd_lb_03",  3'b000, 8'h03, 32'hFFFFFFDE);
        load_chk("rd_lbu_03", 3'b100, 8'h03, 32'h000000DE);
        load_chk("rd_lw_02",  3'b010, 8'h02, 32'hDEADBEEF);

        // Halfword store aligns to 8'h24 -> hex4/hex5
        store(3'b001, 8'h25, 32'h0000A5C3);
        check_val("sh_hex4", {25'h0, hex[4]}, 32'h43);
        check_val("sh_hex5", {25'h0, hex[5]}, 32'h25);
        check_hex_blank_except(4, 5);
        load_chk("rd_lh_24",  3'b001, 8'h24, 32'hFFFFA5C3);
        load_chk("rd_lhu_25", 3'b101, 8'h25, 32'h0000A5C3);
        load_chk("rd_lb_24",  3'b000, 8'h24, 32'hFFFFFFC3);

        // Unmapped and out-of-range stores change nothing
        store(3'b000, 8'h08, 32'h00000055);
        store(3'b010, 8'h3E, 32'hFFFFFFFF);
        store(3'b010, 8'h40, 32'hCAFEF00D);
        store(3'b011, 8'h00, 32'h00000000);
        check_val("unm_ledr", ledr, 32'hDEADBEEF);
        check_val("unm_ledg", ledg, 32'h0);
        check_val("unm_lcd",  lcd,  32'h0);
        check_val("unm_hex0", {25'h0, hex[0]}, 32'h7F);
        check_val("unm_hex4", {25'h0, hex[4]}, 32'h43);
        load_chk("rd_lw_3c", 3'b010, 8'h3C, 32'h0);
        load_chk("rd_lb_08", 3'b000, 8'h08, 32'h0);
        load_chk("rd_lw_40", 3'b010, 8'h40, 32'h0);
        load_chk("rd_bad_f3", 3'b011, 8'h00, 32'h0);

        // Same-cycle store and load return the prior contents
        wren = 1'b1; control = 3'b010; addr = 8'h10; st_data = 32'h12345678;
`ifdef OUT_BUF_READBACK_EN
        #1;
        check_val("rd_before_st", ld_data, 32'h0);
`endif
        tick();
        wren = 1'b0;
        check_val("sw_ledg", ledg, 32'h12345678);

        // Back-to-back byte and halfword stores into the LCD word
        store(3'b000, 8'h31, 32'h000000AB);
        store(3'b001, 8'h33, 32'h00001234);
        check_val("b2b_lcd", lcd, 32'h1234AB00);
        check_val("b2b_ledg", ledg, 32'h12345678);

        // Reset wins over a simultaneous store
        rst = 1'b1; wren = 1'b1; control = 3'b010; addr = 8'h30; st_data = 32'hFFFFFFFF;
        tick();
        rst = 1'b0; wren = 1'b0;
        check_val("rst_wr_lcd",  lcd,  32'h0);
        check_val("rst_wr_ledr", ledr, 32'h0);
        check_val("rst_wr_ledg", ledg, 32'h0);
        check_val("rst_wr_hex4", {25'h0, hex[4]}, 32'h7F);
        tick();
        check_val("rst_hold_lcd", lcd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_output_buffer
`default_nettype wire
